// File: rtl/tap_shift_reg_if.sv
// tap_shift_reg_if: sample handshake and tap bus for tap_shift_reg.
// The sum signal exists only when TAP_SUM_EN is defined.
interface tap_shift_reg_if #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 5,
  parameter int CNT_W = $clog2(DEPTH+1),
  parameter int SUM_W = WIDTH + $clog2(DEPTH)
);
  logic                   din_valid;
  logic [WIDTH-1:0]       din;
  logic                   din_ready;
  logic [WIDTH*DEPTH-1:0] taps;
  logic [CNT_W-1:0]       fill_cnt;
  logic                   full;
  logic                   dout_valid;
`ifdef TAP_SUM_EN
  logic [SUM_W-1:0]       sum;
`endif

  // Upstream producer / downstream adder side
  modport master (
    output din_valid, din,
    input  din_ready, taps, fill_cnt, full, dout_valid
`ifdef TAP_SUM_EN
    , input sum
`endif
  );

  // Delay line side
  modport slave (
    input  din_valid, din,
    output din_ready, taps, fill_cnt, full, dout_valid
`ifdef TAP_SUM_EN
    , output sum
`endif
  );
endinterface

// File: rtl/tap_shift_reg.sv
// tap_shift_reg: parametrised tap delay line feeding the accumulation adder.
// Accepts one sample per clock on din_valid && din_ready, shifts it into
// tap 0, tracks a saturating fill count and pulses dout_valid after every
// accept that leaves the line full.
// Optional feature macro: TAP_SUM_EN -- adds an incremental running sum of
// all taps (sum port on the interface) so the adder stage can be bypassed.

// One tap register. Clear and load share the stage so every tap behaves
// identically under the clr > load priority.
module tap_stage #(
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Tap register: async reset, sync clear, load on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end
endmodule

module tap_shift_reg #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 5,
  parameter int CNT_W = $clog2(DEPTH+1),
  parameter int SUM_W = WIDTH + $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           hold,
  tap_shift_reg_if.slave bus
);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH-1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("tap_shift_reg: DEPTH must be at least 2");
  end

  logic                        accept;
  logic [DEPTH-1:0][WIDTH-1:0] tap_q;
  logic [CNT_W-1:0]            fill_q;
  logic                        dv_q;

  // clr and hold both stall the producer; din_ready is the only
  // combinational output so upstream can hold its sample in place.
  assign bus.din_ready = !hold && !clr;
  assign accept        = bus.din_valid && bus.din_ready;

  // Tap chain: tap 0 loads din, tap k loads tap k-1. All taps move
  // only on accept, so latency to tap k is counted in accepts.
  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    logic [WIDTH-1:0] d;
    if (k == 0) begin : g_head
      assign d = bus.din;
    end else begin : g_body
      assign d = tap_q[k-1];
    end
    tap_stage #(.WIDTH(WIDTH)) u_stage (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (accept),
      .d   (d),
      .q   (tap_q[k])
    );
  end

  // Packed layout puts tap k at [k*WIDTH +: WIDTH]
  assign bus.taps = tap_q;

  // Fill counter: counts accepts, saturates at DEPTH, never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              fill_q <= '0;
    else if (clr)                          fill_q <= '0;
    else if (accept && fill_q != FULL_CNT) fill_q <= fill_q + 1'b1;
  end

  // dout_valid: one-cycle pulse after an accept that leaves the line full.
  // hold and idle both block accept, so they force the pulse low too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     dv_q <= 1'b0;
    else if (clr) dv_q <= 1'b0;
    else          dv_q <= accept && (fill_q >= LAST_CNT);
  end

  assign bus.fill_cnt   = fill_q;
  assign bus.full       = (fill_q == FULL_CNT);
  assign bus.dout_valid = dv_q;

`ifdef TAP_SUM_EN
  // Running sum tracks the window: add the incoming sample, drop the
  // sample falling off the end. Taps are zero after reset/clear, so the
  // partially filled line needs no special case. SUM_W has enough
  // headroom that the sum never overflows.
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] din_x;
  logic [SUM_W-1:0] old_x;

  assign din_x = {{(SUM_W-WIDTH){bus.din[WIDTH-1]}}, bus.din};
  assign old_x = {{(SUM_W-WIDTH){tap_q[DEPTH-1][WIDTH-1]}}, tap_q[DEPTH-1]};

  // Accumulator update on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        sum_q <= '0;
    else if (clr)    sum_q <= '0;
    else if (accept) sum_q <= sum_q + din_x - old_x;
  end

  assign bus.sum = sum_q;
`endif
endmodule
